scfifo_s_core: RTL and testbench
================================

SCFIFO_S_CORE -- requirements
Module: scfifo_s_core

Interface
REQ-001 The block SHALL provide parameter LOG_DEPTH, default 5, address width, legal range 3..5.
REQ-002 The block SHALL provide parameter WIDTH, default 20, data width, >0.
REQ-003 The block SHALL provide parameter ALMOST_FULL_VALUE, default 30, almost_full threshold, legal 4..2^LOG_DEPTH-2.
REQ-004 The block SHALL provide parameter ALMOST_EMPTY_VALUE, default 2, almost_empty threshold, legal 1..2^LOG_DEPTH-5.
REQ-005 The block SHALL provide parameter SHOW_AHEAD, default 0, where 0 = normal read mode and 1 = show-ahead read mode.
REQ-006 The block SHALL provide parameter FAMILY, default "S10", values "Agilex"/"S10"/"Other"; it selects the memory primitive only, with no functional effect.
REQ-007 The block SHALL provide parameters OVERFLOW_CHECKING and UNDERFLOW_CHECKING, default 0, which enable write-when-full and read-when-empty guarding respectively.
REQ-008 Ports (name  direction  width  meaning): clock  in  1  sole clock, all logic rising-edge.
REQ-009 aclr  in  1  reset, asynchronous, active-high.
REQ-010 sclr  in  1  synchronous clear, active-high.
REQ-011 data  in  WIDTH  write data; wrreq  in  1  write request; rdreq  in  1  read request / acknowledge.
REQ-012 q  out  WIDTH  read data; usedw  out  LOG_DEPTH  stored word count.
REQ-013 empty, full, almost_empty, almost_full  out  1 each  status flags.

Function
REQ-014 Capacity SHALL be 2^LOG_DEPTH-1 words (31 at default), stored in a RAM array with registered write and registered read output.
REQ-015 Ordering SHALL be strictly first-in first-out; a write is accepted on an edge with wrreq=1, and a read on an edge with rdreq=1.
REQ-016 usedw SHALL be registered: +1 after an accepted write only, -1 after an accepted read only, and unchanged after a simultaneous accepted read and write.
REQ-017 full SHALL equal (usedw == 2^LOG_DEPTH-1).
REQ-018 almost_full SHALL equal (usedw >= ALMOST_FULL_VALUE).
REQ-019 almost_empty SHALL equal (usedw < ALMOST_EMPTY_VALUE).
REQ-020 All flags SHALL be registered and update on the same edge as usedw.
REQ-021 Normal mode: empty SHALL equal (usedw == 0).
REQ-022 Normal mode: the word read on edge N SHALL appear on q after edge N, and q SHALL hold its value when there is no read.
REQ-023 Show-ahead mode: while empty=0, q SHALL present the head word, and rdreq SHALL pop it so that the next word (if any) is on q after the same edge.
REQ-024 Show-ahead mode: a write into an empty FIFO on edge N SHALL drive empty low and place the word on q after edge N+2; usedw SHALL increment after edge N, so empty may lag usedw by up to 2 cycles.
REQ-025 With OVERFLOW_CHECKING=1, wrreq while full=1 SHALL be ignored; with UNDERFLOW_CHECKING=1, rdreq while empty=1 SHALL be ignored.
REQ-026 With checking disabled, overflow or underflow SHALL NOT be required to have defined behaviour; the user must not issue such requests.
REQ-027 Simultaneous rdreq and wrreq while empty (with underflow checking) SHALL accept the write only; while full (with overflow checking), the read and write SHALL both be accepted.
REQ-028 Read and write pointers SHALL wrap modulo 2^LOG_DEPTH without data loss.

Reset
REQ-029 aclr=1 SHALL immediately force usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, q=0, and pointers=0; RAM contents need not be cleared.
REQ-030 sclr=1 SHALL apply the same state on the next edge and SHALL take priority over wrreq and rdreq in that cycle.
REQ-031 Reset mid-operation SHALL discard all stored words; the first write after reset SHALL be the first word read.

Verification
REQ-032 Defaults, normal mode: after aclr, write 0x00001..0x0001F in 31 cycles -> usedw=31, full=1, almost_full=1 from usedw=30; then read 31 -> q=0x00001..0x0001F in order, each on the cycle after its rdreq.
REQ-033 Flags at boundaries: with ALMOST_EMPTY_VALUE=2, usedw 0/1/2 -> almost_empty 1/1/0, and empty=1 only at usedw=0.
REQ-034 Show-ahead: write 0xABCDE into empty FIFO -> empty=0 and q=0xABCDE two cycles after the write edge; a single rdreq -> empty=1 and usedw=0.
REQ-035 With OVERFLOW_CHECKING=1 and UNDERFLOW_CHECKING=1: write 32 words -> usedw=31 and the 32nd word is dropped; rdreq on empty -> usedw remains 0.
REQ-036 Simultaneous rdreq and wrreq at usedw=10 for 50 cycles -> usedw stays 10, data order is preserved, and pointers wrap.
REQ-037 sclr pulse with usedw=5 -> usedw=0 and empty=1 after the edge; aclr asserted mid-cycle -> flags reset without a clock edge.

Source files
------------

// File: rtl/scfifo_s_core.sv
// Single-clock FIFO with registered usedw/status flags, normal or show-ahead read
// mode, and optional write-when-full / read-when-empty guarding.
module scfifo_s_core #(
    parameter int    LOG_DEPTH          = 5,
    parameter int    WIDTH              = 20,
    parameter int    ALMOST_FULL_VALUE  = 30,
    parameter int    ALMOST_EMPTY_VALUE = 2,
    parameter int    SHOW_AHEAD         = 0,
    parameter string FAMILY             = "S10",
    parameter int    OVERFLOW_CHECKING  = 0,
    parameter int    UNDERFLOW_CHECKING = 0
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 sclr,
    input  logic [WIDTH-1:0]     data,
    input  logic                 wrreq,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
    output logic [LOG_DEPTH-1:0] usedw,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full
);

    localparam int                   DEPTH  = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] ONE    = LOG_DEPTH'(1);
    localparam logic [LOG_DEPTH-1:0] CAP    = LOG_DEPTH'(DEPTH - 1);
    localparam logic [LOG_DEPTH-1:0] AF_LVL = LOG_DEPTH'(ALMOST_FULL_VALUE);
    localparam logic [LOG_DEPTH-1:0] AE_LVL = LOG_DEPTH'(ALMOST_EMPTY_VALUE);

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH-1:0] usedw_q, usedw_d;
    logic [LOG_DEPTH-1:0] ram_cnt_q, ram_cnt_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     s1_data_q, s1_data_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s2_vld_q, s2_vld_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 ae_q, ae_d;
    logic                 af_q, af_d;

    logic                 rd_ok, wr_ok, ram_we;
    logic                 pop, s2_load, fetch;
    logic [WIDTH-1:0]     ram_rdata;

    // A read while full frees a slot, so the paired write is still accepted.
    assign rd_ok  = rdreq && ((UNDERFLOW_CHECKING == 0) || !empty_q);
    assign wr_ok  = wrreq && ((OVERFLOW_CHECKING == 0) || !full_q || rd_ok);
    assign ram_we = wr_ok && !sclr;

    generate
        if (FAMILY == "Other") begin : g_ram_generic
            logic [WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge clock) begin
                if (ram_we) mem[wr_ptr_q] <= data;
            end
            assign ram_rdata = mem[rd_ptr_q];
        end else begin : g_ram_block
            (* ramstyle = "M20K" *) logic [WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge clock) begin
                if (ram_we) mem[wr_ptr_q] <= data;
            end
            assign ram_rdata = mem[rd_ptr_q];
        end
    endgenerate

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        usedw_d   = usedw_q;
        ram_cnt_d = ram_cnt_q;
        q_d       = q_q;
        s1_data_d = s1_data_q;
        s1_vld_d  = s1_vld_q;
        s2_vld_d  = s2_vld_q;
        pop       = 1'b0;
        s2_load   = 1'b0;
        fetch     = 1'b0;

        if (wr_ok) wr_ptr_d = wr_ptr_q + ONE;

        if (wr_ok && !rd_ok)      usedw_d = usedw_q + ONE;
        else if (rd_ok && !wr_ok) usedw_d = usedw_q - ONE;

        if (SHOW_AHEAD == 0) begin
            if (rd_ok) begin
                q_d      = ram_rdata;
                rd_ptr_d = rd_ptr_q + ONE;
            end
            empty_d = (usedw_d == '0);
        end else begin
            // Two-stage prefetch: RAM -> s1 -> q. q holds the head while s2 is valid.
            pop     = rd_ok && s2_vld_q;
            s2_load = s1_vld_q && (!s2_vld_q || pop);
            fetch   = (ram_cnt_q != '0) && (!s1_vld_q || s2_load);

            if (s2_load) begin
                q_d      = s1_data_q;
                s2_vld_d = 1'b1;
            end else if (pop) begin
                s2_vld_d = 1'b0;
            end

            if (fetch) begin
                s1_data_d = ram_rdata;
                s1_vld_d  = 1'b1;
                rd_ptr_d  = rd_ptr_q + ONE;
            end else if (s2_load) begin
                s1_vld_d  = 1'b0;
            end

            if (wr_ok && !fetch)      ram_cnt_d = ram_cnt_q + ONE;
            else if (fetch && !wr_ok) ram_cnt_d = ram_cnt_q - ONE;

            empty_d = !s2_vld_d;
        end

        full_d = (usedw_d == CAP);
        af_d   = (usedw_d >= AF_LVL);
        ae_d   = (usedw_d < AE_LVL);

        if (sclr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            usedw_d   = '0;
            ram_cnt_d = '0;
            q_d       = '0;
            s1_data_d = '0;
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            empty_d   = 1'b1;
            full_d    = 1'b0;
            ae_d      = 1'b1;
            af_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            ram_cnt_q <= '0;
            q_q       <= '0;
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ae_q      <= 1'b1;
            af_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usedw_q   <= usedw_d;
            ram_cnt_q <= ram_cnt_d;
            q_q       <= q_d;
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ae_q      <= ae_d;
            af_q      <= af_d;
        end
    end

    assign q            = q_q;
    assign usedw        = usedw_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;

endmodule

// File: tb/tb_scfifo_s_core.sv
// Scoreboard bench: instance A in normal mode, instance B in show-ahead mode,
// both with overflow/underflow guarding enabled.
module tb_scfifo_s_core;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         aclr, sclr_a, sclr_b;
    logic         wr_a, rd_a, wr_b, rd_b;
    logic [W-1:0] d_a, d_b, q_a, q_b;
    logic [4:0]   uw_a, uw_b;
    logic         em_a, fu_a, ae_a, af_a;
    logic         em_b, fu_b, ae_b, af_b;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] model_a[$];
    logic [W-1:0] exp_a[$];
    logic [W-1:0] model_b[$];
    logic [W-1:0] exp_b[$];
    bit           fire_a = 1'b0;

    always #5 clk = ~clk;

    scfifo_s_core #(
        .SHOW_AHEAD(0), .OVERFLOW_CHECKING(1), .UNDERFLOW_CHECKING(1)
    ) u_a (
        .clock(clk), .aclr(aclr), .sclr(sclr_a), .data(d_a), .wrreq(wr_a), .rdreq(rd_a),
        .q(q_a), .usedw(uw_a), .empty(em_a), .full(fu_a),
        .almost_empty(ae_a), .almost_full(af_a)
    );

    scfifo_s_core #(
        .SHOW_AHEAD(1), .OVERFLOW_CHECKING(1), .UNDERFLOW_CHECKING(1)
    ) u_b (
        .clock(clk), .aclr(aclr), .sclr(sclr_b), .data(d_b), .wrreq(wr_b), .rdreq(rd_b),
        .q(q_b), .usedw(uw_b), .empty(em_b), .full(fu_b),
        .almost_empty(ae_b), .almost_full(af_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor A: a read accepted on an edge presents its word on q after that edge.
    always @(posedge clk) fire_a <= rd_a && (exp_a.size() > 0);
    always @(negedge clk) begin
        if (fire_a && exp_a.size() > 0) chk("a_rd_data", 32'(q_a), 32'(exp_a.pop_front()));
    end

    // Monitor B: the head word on q is what an accepted rdreq consumes.
    always @(negedge clk) begin
        if (rd_b && exp_b.size() > 0) chk("b_head_data", 32'(q_b), 32'(exp_b.pop_front()));
    end

    task automatic check_a_status();
        int n;
        n = model_a.size();
        chk("a_usedw", 32'(uw_a), 32'(n));
        chk("a_empty", 32'(em_a), 32'(n == 0));
        chk("a_full", 32'(fu_a), 32'(n == 31));
        chk("a_almost_full", 32'(af_a), 32'(n >= 30));
        chk("a_almost_empty", 32'(ae_a), 32'(n < 2));
    endtask

    task automatic step_a(input bit wr, input bit rd, input logic [W-1:0] d);
        bit ra, wa;
        ra = rd && (model_a.size() > 0);
        wa = wr && ((model_a.size() < 31) || ra);
        wr_a = wr; rd_a = rd; d_a = d;
        if (ra) exp_a.push_back(model_a.pop_front());
        if (wa) model_a.push_back(d);
        @(posedge clk); #1;
        wr_a = 1'b0; rd_a = 1'b0;
        check_a_status();
    endtask

    task automatic drive_b(input bit wr, input bit rd, input logic [W-1:0] d);
        wr_b = wr; rd_b = rd; d_b = d;
        @(posedge clk); #1;
        wr_b = 1'b0; rd_b = 1'b0;
    endtask

    task automatic stream_b(input bit wr, input bit rd, input logic [W-1:0] d);
        if (rd && model_b.size() > 0) exp_b.push_back(model_b.pop_front());
        if (wr) model_b.push_back(d);
        drive_b(wr, rd, d);
        chk("b_usedw", 32'(uw_b), 32'(model_b.size()));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aclr = 1'b1; sclr_a = 1'b0; sclr_b = 1'b0;
        wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
        d_a = '0; d_b = '0;
        #2;
        check_a_status();
        chk("a_q_reset", 32'(q_a), 32'h0);
        chk("b_usedw_reset", 32'(uw_b), 32'h0);
        chk("b_empty_reset", 32'(em_b), 32'h1);
        chk("b_ae_reset", 32'(ae_b), 32'h1);
        chk("b_af_reset", 32'(af_b), 32'h0);
        chk("b_full_reset", 32'(fu_b), 32'h0);
        @(posedge clk); #1;
        aclr = 1'b0;

        // Fill to capacity; the 32nd write is dropped by overflow guarding.
        for (int i = 1; i <= 32; i++) step_a(1'b1, 1'b0, W'(i));
        for (int i = 1; i <= 31; i++) step_a(1'b0, 1'b1, '0);
        step_a(1'b0, 1'b1, '0);
        chk("a_q_hold_after_empty_rd", 32'(q_a), 32'h1F);

        // Concurrent read/write at depth 10, long enough for both pointers to wrap.
        for (int i = 0; i < 10; i++) step_a(1'b1, 1'b0, W'(32'h100 + i));
        for (int j = 0; j < 50; j++) step_a(1'b1, 1'b1, W'(32'h200 + j));
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b1, '0);

        // Synchronous clear beats a simultaneous write.
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, W'(32'h300 + i));
        sclr_a = 1'b1; wr_a = 1'b1; d_a = W'(32'h3FF);
        model_a.delete();
        @(posedge clk); #1;
        sclr_a = 1'b0; wr_a = 1'b0;
        check_a_status();
        chk("a_q_after_sclr", 32'(q_a), 32'h0);
        step_a(1'b1, 1'b0, W'(32'h55));
        step_a(1'b0, 1'b1, '0);
        step_a(1'b0, 1'b0, '0);

        // Asynchronous clear between edges.
        for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, W'(32'h400 + i));
        #2;
        aclr = 1'b1;
        model_a.delete();
        #1;
        check_a_status();
        chk("a_q_after_aclr", 32'(q_a), 32'h0);
        @(posedge clk); #1;
        aclr = 1'b0;
        step_a(1'b1, 1'b0, W'(32'h66));
        step_a(1'b0, 1'b1, '0);
        step_a(1'b0, 1'b0, '0);

        // Show-ahead: head appears two edges after a write into an empty FIFO.
        drive_b(1'b1, 1'b0, W'(32'hABCDE));
        chk("b_usedw_after_wr", 32'(uw_b), 32'h1);
        chk("b_empty_lag1", 32'(em_b), 32'h1);
        drive_b(1'b0, 1'b0, '0);
        chk("b_empty_lag2", 32'(em_b), 32'h1);
        drive_b(1'b0, 1'b0, '0);
        chk("b_empty_ready", 32'(em_b), 32'h0);
        chk("b_q_ready", 32'(q_b), 32'hABCDE);
        exp_b.push_back(W'(32'hABCDE));
        drive_b(1'b0, 1'b1, '0);
        chk("b_empty_after_pop", 32'(em_b), 32'h1);
        chk("b_usedw_after_pop", 32'(uw_b), 32'h0);
        drive_b(1'b0, 1'b1, '0);
        chk("b_usedw_underflow", 32'(uw_b), 32'h0);
        chk("b_empty_underflow", 32'(em_b), 32'h1);

        // Show-ahead burst, then back-to-back pops.
        for (int i = 0; i < 5; i++) stream_b(1'b1, 1'b0, W'(32'h10 + i));
        drive_b(1'b0, 1'b0, '0);
        drive_b(1'b0, 1'b0, '0);
        chk("b_burst_empty", 32'(em_b), 32'h0);
        chk("b_burst_head", 32'(q_b), 32'h10);
        for (int i = 0; i < 5; i++) stream_b(1'b0, 1'b1, '0);
        chk("b_burst_drained", 32'(em_b), 32'h1);

        // Show-ahead concurrent read/write at depth 3.
        for (int i = 0; i < 3; i++) stream_b(1'b1, 1'b0, W'(32'h20 + i));
        drive_b(1'b0, 1'b0, '0);
        drive_b(1'b0, 1'b0, '0);
        for (int j = 0; j < 10; j++) stream_b(1'b1, 1'b1, W'(32'h50 + j));
        for (int i = 0; i < 3; i++) stream_b(1'b0, 1'b1, '0);
        chk("b_stream_empty", 32'(em_b), 32'h1);

        repeat (3) @(posedge clk);
        #1;
        chk("a_scoreboard_drained", 32'(exp_a.size()), 32'h0);
        chk("b_scoreboard_drained", 32'(exp_b.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
